// File: rtl/fft_out_addr_gen.sv
// Read-address sequencer for the FFT output buffer: runtime frame length,
// natural or bit-reversed order, ready backpressure, abort and RAM-latency-aligned flags.
module fft_out_addr_gen #(
    parameter int unsigned MAX_LOG2N = 4,
    parameter int unsigned LW        = 3,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [LW-1:0]        i_len_log2,
    input  logic                 i_bitrev_en,
    input  logic                 i_out_ready,
    input  logic                 i_abort,
    output logic                 o_rd_en,
    output logic [MAX_LOG2N-1:0] o_rd_ptr,
    output logic                 o_rd_last,
    output logic                 o_data_valid,
    output logic                 o_data_last,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err_cfg
);

    localparam int unsigned   CW      = MAX_LOG2N + 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LOG2N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [LW-1:0]          r_len;
    logic                   r_bitrev;
    logic [CW-1:0]          r_cnt;
    logic [MAX_LOG2N-1:0]   r_rd_ptr;
    logic                   r_rd_en;
    logic                   r_rd_last;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err_cfg;
    logic [RD_LAT-1:0]      r_pipe_v;
    logic [RD_LAT-1:0]      r_pipe_l;

    logic                   w_len_ok;
    logic [CW-1:0]          w_n;
    logic                   w_cnt_last;
    logic                   w_issue;
    logic [MAX_LOG2N-1:0]   w_rev_full;
    logic [LW-1:0]          w_shamt;
    logic [MAX_LOG2N-1:0]   w_map;

    assign w_len_ok   = (i_len_log2 != '0) && (i_len_log2 <= LEN_MAX);
    assign w_n        = CW'(1) << r_len;
    assign w_cnt_last = (r_cnt == (w_n - CW'(1)));
    assign w_issue    = (r_cnt < w_n) && i_out_ready;

    // Full-width reversal, then shift down so only the low L reversed bits remain
    // (cnt bits above L are zero while cnt < N, so the vacated top bits are zero).
    for (genvar g = 0; g < MAX_LOG2N; g++) begin : g_rev
        assign w_rev_full[g] = r_cnt[MAX_LOG2N-1-g];
    end

    assign w_shamt = LEN_MAX - r_len;
    assign w_map   = r_bitrev ? (w_rev_full >> w_shamt) : r_cnt[MAX_LOG2N-1:0];

    // Frame sequencer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_bitrev  <= 1'b0;
            r_cnt     <= '0;
            r_rd_ptr  <= '0;
            r_rd_en   <= 1'b0;
            r_rd_last <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err_cfg <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_err_cfg <= 1'b0;
            if (i_abort) begin
                r_state   <= S_IDLE;
                r_rd_en   <= 1'b0;
                r_rd_last <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_rd_en   <= 1'b0;
                        r_rd_last <= 1'b0;
                        if (i_start) begin
                            if (w_len_ok) begin
                                r_len    <= i_len_log2;
                                r_bitrev <= i_bitrev_en;
                                r_cnt    <= '0;
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end else begin
                                r_err_cfg <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_issue) begin
                            r_rd_en   <= 1'b1;
                            r_rd_ptr  <= w_map;
                            r_rd_last <= w_cnt_last;
                            r_cnt     <= r_cnt + CW'(1);
                            if (w_cnt_last) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_rd_en   <= 1'b0;
                            r_rd_last <= 1'b0;
                        end
                    end
                    S_DRAIN: begin
                        r_rd_en   <= 1'b0;
                        r_rd_last <= 1'b0;
                        if (r_pipe_l[RD_LAT-1]) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // RAM read-latency delay line for the valid/last flags
    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pipe_v <= '0;
                r_pipe_l <= '0;
            end else if (i_abort) begin
                r_pipe_v <= '0;
                r_pipe_l <= '0;
            end else begin
                r_pipe_v <= r_rd_en;
                r_pipe_l <= r_rd_last;
            end
        end
    end else begin : g_latn
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pipe_v <= '0;
                r_pipe_l <= '0;
            end else if (i_abort) begin
                r_pipe_v <= '0;
                r_pipe_l <= '0;
            end else begin
                r_pipe_v <= {r_pipe_v[RD_LAT-2:0], r_rd_en};
                r_pipe_l <= {r_pipe_l[RD_LAT-2:0], r_rd_last};
            end
        end
    end

    assign o_rd_en      = r_rd_en;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_rd_last    = r_rd_last;
    assign o_data_valid = r_pipe_v[RD_LAT-1];
    assign o_data_last  = r_pipe_l[RD_LAT-1];
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err_cfg    = r_err_cfg;

endmodule

// File: tb/tb_fft_out_addr_gen.sv
// Directed bench for fft_out_addr_gen: two instances (read latency 1 and 3) share
// stimulus; expected addresses go through a scoreboard queue, flags through a timeline.
module tb_fft_out_addr_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] len_log2;
    logic       bitrev_en;
    logic       out_ready;
    logic       abort;

    logic       a_rd_en, a_rd_last, a_dv, a_dl, a_busy, a_done, a_err;
    logic [3:0] a_ptr;
    logic       b_rd_en, b_rd_last, b_dv, b_dl, b_busy, b_done, b_err;
    logic [3:0] b_ptr;

    int n_cmp = 0;
    int n_err = 0;
    int q_a[$];
    int q_b[$];
    int hold_a = 0;
    int hold_b = 0;
    bit e_en[64];
    bit e_last[64];
    bit rdy[64];

    fft_out_addr_gen #(.MAX_LOG2N(4), .LW(3), .RD_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_len_log2(len_log2),
        .i_bitrev_en(bitrev_en), .i_out_ready(out_ready), .i_abort(abort),
        .o_rd_en(a_rd_en), .o_rd_ptr(a_ptr), .o_rd_last(a_rd_last),
        .o_data_valid(a_dv), .o_data_last(a_dl), .o_busy(a_busy),
        .o_done(a_done), .o_err_cfg(a_err)
    );

    fft_out_addr_gen #(.MAX_LOG2N(4), .LW(3), .RD_LAT(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_len_log2(len_log2),
        .i_bitrev_en(bitrev_en), .i_out_ready(out_ready), .i_abort(abort),
        .o_rd_en(b_rd_en), .o_rd_ptr(b_ptr), .o_rd_last(b_rd_last),
        .o_data_valid(b_dv), .o_data_last(b_dl), .o_busy(b_busy),
        .o_done(b_done), .o_err_cfg(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int v, input int len);
        int r;
        r = 0;
        for (int i = 0; i < len; i++)
            if (((v >> i) & 1) == 1) r = r | (1 << (len - 1 - i));
        return r;
    endfunction

    task automatic check_zero(input string nm, input logic en, input logic [3:0] ptr,
                              input logic last, input logic dv, input logic dl,
                              input logic busy, input logic done, input logic err);
        check({nm, " rd_en"}, 32'(en), 0);
        check({nm, " rd_ptr"}, 32'(ptr), 0);
        check({nm, " rd_last"}, 32'(last), 0);
        check({nm, " data_valid"}, 32'(dv), 0);
        check({nm, " data_last"}, 32'(dl), 0);
        check({nm, " busy"}, 32'(busy), 0);
        check({nm, " done"}, 32'(done), 0);
        check({nm, " err_cfg"}, 32'(err), 0);
    endtask

    task automatic check_dut(input int which, input int lat, input int c, input bit bad,
                             input int abort_at, input int last_en_c,
                             input logic en, input logic [3:0] ptr, input logic last,
                             input logic dv, input logic dl, input logic busy,
                             input logic done, input logic err);
        string nm;
        bit    ab;
        bit    aborted;
        bit    edv;
        bit    edl;
        bit    ebusy;
        int    done_c;
        int    exp_ptr;
        nm      = $sformatf("%s c%0d", (which == 0) ? "L1" : "L3", c);
        aborted = (abort_at >= 0);
        ab      = aborted && (c > abort_at);
        done_c  = last_en_c + 1 + lat;
        edv     = (!ab && c >= lat) ? e_en[c-lat] : 1'b0;
        edl     = (!ab && c >= lat) ? e_last[c-lat] : 1'b0;
        ebusy   = !bad && (c >= 1) && (aborted ? (c <= abort_at) : (c <= done_c));
        check({nm, " rd_en"}, 32'(en), 32'(e_en[c]));
        check({nm, " rd_last"}, 32'(last), 32'(e_last[c]));
        check({nm, " data_valid"}, 32'(dv), 32'(edv));
        check({nm, " data_last"}, 32'(dl), 32'(edl));
        check({nm, " busy"}, 32'(busy), 32'(ebusy));
        check({nm, " done"}, 32'(done), 32'(!bad && !aborted && c == done_c));
        check({nm, " err_cfg"}, 32'(err), 32'(bad && c == 1));
        if (en === 1'b1) begin
            if (which == 0) begin
                check({nm, " ptr_q_nonempty"}, 32'(q_a.size() != 0), 1);
                if (q_a.size() != 0) begin
                    exp_ptr = q_a.pop_front();
                    hold_a  = exp_ptr;
                    check({nm, " rd_ptr"}, 32'(ptr), 32'(exp_ptr));
                end
            end else begin
                check({nm, " ptr_q_nonempty"}, 32'(q_b.size() != 0), 1);
                if (q_b.size() != 0) begin
                    exp_ptr = q_b.pop_front();
                    hold_b  = exp_ptr;
                    check({nm, " rd_ptr"}, 32'(ptr), 32'(exp_ptr));
                end
            end
        end
        if (ab) check({nm, " rd_ptr_hold"}, 32'(ptr), 32'((which == 0) ? hold_a : hold_b));
    endtask

    // rmode 0: ready always high; rmode 1: ready high on odd cycles only
    task automatic run_test(input int len, input bit rev, input int rmode,
                            input int abort_at, input int xstart_at);
        bit bad;
        int n;
        int cnt;
        int last_en_c;
        int ncyc;
        bad       = (len == 0) || (len > 4);
        n         = bad ? 0 : (1 << len);
        last_en_c = 0;
        for (int c = 0; c < 64; c++) begin
            e_en[c]   = 1'b0;
            e_last[c] = 1'b0;
            rdy[c]    = (rmode == 0) ? 1'b1 : ((c % 2) == 1);
        end
        cnt = 0;
        for (int c = 1; c < 60 && cnt < n; c++) begin
            if (abort_at >= 0 && c >= abort_at) break;
            if (rdy[c]) begin
                e_en[c+1]   = 1'b1;
                e_last[c+1] = (cnt == n - 1);
                last_en_c   = c + 1;
                cnt++;
            end
        end
        for (int i = 0; i < n; i++) begin
            q_a.push_back(rev ? brev(i, len) : i);
            q_b.push_back(rev ? brev(i, len) : i);
        end
        ncyc = (abort_at >= 0) ? abort_at + 4 : (bad ? 4 : last_en_c + 7);
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            check_dut(0, 1, c, bad, abort_at, last_en_c,
                      a_rd_en, a_ptr, a_rd_last, a_dv, a_dl, a_busy, a_done, a_err);
            check_dut(1, 3, c, bad, abort_at, last_en_c,
                      b_rd_en, b_ptr, b_rd_last, b_dv, b_dl, b_busy, b_done, b_err);
            start     = (c == 0) || (c == xstart_at);
            len_log2  = (c == 0) ? 3'(len) : 3'd2;
            bitrev_en = (c == 0) ? rev : !rev;
            out_ready = rdy[c];
            abort     = (c == abort_at);
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        if (abort_at >= 0) begin
            q_a.delete();
            q_b.delete();
        end else begin
            check("L1 ptr_q_drained", 32'(q_a.size()), 0);
            check("L3 ptr_q_drained", 32'(q_b.size()), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len_log2 = '0; bitrev_en = 1'b0;
        out_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("L1 reset", a_rd_en, a_ptr, a_rd_last, a_dv, a_dl, a_busy, a_done, a_err);
        check_zero("L3 reset", b_rd_en, b_ptr, b_rd_last, b_dv, b_dl, b_busy, b_done, b_err);
        rst_n = 1'b1;

        run_test(4, 1'b1, 0, -1, -1);   // 16-point bit-reversed
        run_test(3, 1'b1, 0, -1, -1);   // 8-point bit-reversed
        run_test(2, 1'b0, 1, -1, -1);   // 4-point natural, ready toggling
        run_test(4, 1'b1, 0, 6, -1);    // abort after 5 reads
        run_test(4, 1'b0, 0, -1, -1);   // restart from 0 after abort
        run_test(0, 1'b0, 0, -1, -1);   // len 0 rejected
        run_test(5, 1'b0, 0, -1, -1);   // len above max rejected
        run_test(3, 1'b0, 0, -1, 5);    // start while busy ignored

        // Asynchronous reset in the middle of a frame
        @(negedge clk);
        start = 1'b1; len_log2 = 3'd4; bitrev_en = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero("L1 midrst", a_rd_en, a_ptr, a_rd_last, a_dv, a_dl, a_busy, a_done, a_err);
        check_zero("L3 midrst", b_rd_en, b_ptr, b_rd_last, b_dv, b_dl, b_busy, b_done, b_err);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        run_test(4, 1'b1, 1, -1, -1);   // 16-point bit-reversed, ready toggling

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_out_addr_gen.md
# fft_out_addr_gen

Parametrised read-address sequencer for the FFT output buffer. It replaces the fixed-size, bit-reversed-only output reader. It handles:
- runtime frame length up to 2^MAX_LOG2N
- selectable bit-reversed or natural order
- a downstream ready handshake
- abort
- a configurable RAM read-latency pipeline that delivers aligned valid/last flags to the serialiser.

## Interface
- MAX_LOG2N, 4, log2 of largest supported frame; rd_ptr width.
- LW, 3, width of len_log2; must satisfy 2^LW > MAX_LOG2N.
- RD_LAT, 1, output-RAM read latency in cycles, legal 1..4.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start request; ignored unless idle.
- len_log2  in  LW  frame length L, N=2^L; sampled with start.
- bitrev_en  in  1  1 = bit-reversed order over L bits, 0 = natural; sampled with start.
- out_ready  in  1  downstream can accept one more element.
- abort  in  1  synchronous frame cancel, highest priority after reset.
- rd_en  out  1  RAM read strobe, one cycle per element.
- rd_ptr  out  MAX_LOG2N  RAM read address.
- rd_last  out  1  marks final rd_en of frame.
- data_valid  out  1  rd_en delayed RD_LAT cycles (RAM data valid).
- data_last  out  1  rd_last delayed RD_LAT cycles.
- busy  out  1  frame in progress.
- done_o  out  1  one-cycle pulse at frame completion.
- err_cfg  out  1  one-cycle pulse on rejected configuration.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - start=1 with 1 ≤ len_log2 ≤ MAX_LOG2N: latch L and bitrev_en, clear element counter cnt (MAX_LOG2N+1 bits), go to RUN.
  - start=1 with len_log2 = 0 or len_log2 > MAX_LOG2N: pulse err_cfg next cycle, stay in IDLE.
- **RUN**
  - An element is issued on each edge where cnt < N and out_ready=1.
  - On issue, at that edge: rd_en←1, rd_ptr←map(cnt), rd_last←(cnt==N-1), cnt←cnt+1.
  - If out_ready=0, rd_en←0 and rd_ptr holds.
  - After the issue with cnt==N-1, go to DRAIN.
- map(cnt):
  - bitrev_en=1: low L bits are cnt[L-1:0] reversed; upper MAX_LOG2N-L bits are 0.
  - bitrev_en=0: cnt[MAX_LOG2N-1:0].
- **DRAIN**: wait until the final element has left the RD_LAT pipeline (data_last seen), then go to DONE.
- **DONE**: done_o=1 for one cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE; busy=0 in IDLE.
- The delay pipeline is a RD_LAT-deep shift register of {rd_en, rd_last} producing {data_valid, data_last}.
- abort=1 in any state:
  - next cycle: state IDLE; rd_en, rd_last, busy, data_valid, data_last and the whole pipeline cleared.
  - no done_o.
  - rd_ptr holds its last value.
- start while busy is ignored. start and abort in the same cycle: abort wins, start is dropped.
- Reset values: state IDLE, cnt 0, rd_ptr 0; every 1-bit output 0; pipeline cleared.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Timeline with start high in cycle 0 and out_ready held 1:
  - busy=1 from cycle 1.
  - rd_en=1 in cycles 2..N+1.
  - data_valid=1 in cycles 2+RD_LAT..N+1+RD_LAT.
  - done_o=1 in cycle N+2+RD_LAT.
  - busy=0 from cycle N+3+RD_LAT.
- Throughput is 1 element/cycle. out_ready low for k cycles inserts exactly k idle cycles into rd_en.
- out_ready is not sampled in DRAIN/DONE. In-flight data is emitted regardless; the downstream must absorb RD_LAT elements after deasserting ready.
- err_cfg appears the cycle after the offending start.
- A new start is accepted from the first IDLE cycle after done_o or abort.

## Test plan
- Reset, MAX_LOG2N=4, RD_LAT=1, start with len_log2=4, bitrev_en=1, out_ready=1:
  - rd_ptr 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - rd_last only with 15; done_o in cycle 19; no gaps.
- len_log2=3, bitrev_en=1: rd_ptr 0,4,2,6,1,5,3,7 (upper bit 0); done_o in cycle 11.
- len_log2=2, bitrev_en=0, out_ready toggling 1,0,1,0,...:
  - rd_ptr 0,1,2,3, each separated by one idle cycle.
  - data_valid is rd_en delayed RD_LAT cycles (repeat with RD_LAT=3).
- Abort mid-frame after 5 reads of a 16-point frame:
  - rd_en, data_valid and busy low next cycle; no done_o.
  - a following start yields rd_ptr sequence restarting at 0.
- Bad config:
  - start with len_log2=0 → err_cfg pulse, busy stays 0.
  - start with len_log2=5 (MAX_LOG2N=4) → err_cfg pulse, busy stays 0.
  - start asserted while busy → ignored, current frame completes unchanged.
- rst_n asserted mid-RUN → all outputs 0 immediately; resumes normally after release.
